// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: decodes the IF/ID instruction, reads operands with
// optional writeback bypass, stalls on load-use hazards and registers the bundle for EX.
module decode_stage #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 32'h8000_0000,
  parameter bit                    WB_BYPASS  = 1'b1,
  parameter bit                    EN_SYSTEM  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  input  logic [31:0]           in_instr,
  input  logic                  flush,
  input  logic                  ex_load_pending,
  input  logic [4:0]            ex_load_rd,
  output logic [4:0]            rf_raddr_a,
  output logic [4:0]            rf_raddr_b,
  input  logic [DATA_WIDTH-1:0] rf_rdata_a,
  input  logic [DATA_WIDTH-1:0] rf_rdata_b,
  input  logic                  wb_we,
  input  logic [4:0]            wb_waddr,
  input  logic [DATA_WIDTH-1:0] wb_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [3:0]            out_imm_type,
  output logic [4:0]            out_rs1,
  output logic [4:0]            out_rs2,
  output logic [4:0]            out_rd,
  output logic [DATA_WIDTH-1:0] out_rs1_data,
  output logic [DATA_WIDTH-1:0] out_rs2_data,
  output logic [6:0]            out_opcode,
  output logic [2:0]            out_funct3,
  output logic                  out_funct7_5,
  output logic                  out_rf_we,
  output logic                  out_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [6:0]            opcode;
  logic                  uses_rs1;
  logic                  uses_rs2;
  logic                  writes;
  logic                  illegal;
  logic [31:0]           imm32;
  logic [3:0]            imm_type;
  logic [DATA_WIDTH-1:0] imm_ext;
  logic [4:0]            rd;
  logic                  rf_we;
  logic                  hazard;
  logic                  accept;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;

  // x0 reads zero; a same-cycle writeback to the read address wins over the regfile
  function automatic logic [DATA_WIDTH-1:0] operand(
    input logic [4:0]            addr,
    input logic [DATA_WIDTH-1:0] rdata,
    input logic                  we,
    input logic [4:0]            waddr,
    input logic [DATA_WIDTH-1:0] wdata
  );
    if (addr == 5'd0) begin
      return {DATA_WIDTH{1'b0}};
    end else if (WB_BYPASS && we && (waddr == addr)) begin
      return wdata;
    end else begin
      return rdata;
    end
  endfunction

  assign opcode = in_instr[6:0];

  // Opcode decode: operand usage, rd write, immediate format and legality
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    writes   = 1'b0;
    illegal  = 1'b0;
    imm32    = 32'd0;
    imm_type = 4'b0000;
    if (in_instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opcode)
        OP_LUI, OP_AUIPC: begin
          writes   = 1'b1;
          imm32    = {in_instr[31:12], 12'd0};
          imm_type = 4'b1011;
        end
        OP_JAL: begin
          writes   = 1'b1;
          imm32    = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
          imm_type = 4'b1001;
        end
        OP_JALR, OP_LOAD, OP_IMM: begin
          uses_rs1 = 1'b1;
          writes   = 1'b1;
          imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
          imm_type = 4'b1000;
        end
        OP_STORE: begin
          uses_rs1 = 1'b1;
          uses_rs2 = 1'b1;
          imm32    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
          imm_type = 4'b1010;
        end
        OP_BRANCH: begin
          uses_rs1 = 1'b1;
          uses_rs2 = 1'b1;
          imm32    = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
          imm_type = 4'b1100;
        end
        OP_OP: begin
          uses_rs1 = 1'b1;
          uses_rs2 = 1'b1;
          writes   = 1'b1;
        end
        OP_FENCE, OP_SYSTEM: begin
          illegal = !EN_SYSTEM;
        end
        default: begin
          illegal = 1'b1;
        end
      endcase
    end
  end

  assign imm_ext    = {{(DATA_WIDTH-31){imm32[31]}}, imm32[30:0]};
  assign rd         = writes ? in_instr[11:7] : 5'd0;
  assign rf_we      = writes && (rd != 5'd0);
  assign rf_raddr_a = uses_rs1 ? in_instr[19:15] : 5'd0;
  assign rf_raddr_b = uses_rs2 ? in_instr[24:20] : 5'd0;

  assign hazard = in_valid && ex_load_pending && (ex_load_rd != 5'd0) &&
                  ((uses_rs1 && (in_instr[19:15] == ex_load_rd)) ||
                   (uses_rs2 && (in_instr[24:20] == ex_load_rd)));

  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;
  assign rs1_data = operand(rf_raddr_a, rf_rdata_a, wb_we, wb_waddr, wb_wdata);
  assign rs2_data = operand(rf_raddr_b, rf_rdata_b, wb_we, wb_waddr, wb_wdata);

  // Output bundle register: flush beats accept, accept beats bubble, otherwise hold
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_pc       <= PC_ADDR;
      out_imm      <= {DATA_WIDTH{1'b0}};
      out_imm_type <= 4'd0;
      out_rs1      <= 5'd0;
      out_rs2      <= 5'd0;
      out_rd       <= 5'd0;
      out_rs1_data <= {DATA_WIDTH{1'b0}};
      out_rs2_data <= {DATA_WIDTH{1'b0}};
      out_opcode   <= 7'd0;
      out_funct3   <= 3'd0;
      out_funct7_5 <= 1'b0;
      out_rf_we    <= 1'b0;
      out_illegal  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_imm      <= imm_ext;
      out_imm_type <= imm_type;
      out_rs1      <= rf_raddr_a;
      out_rs2      <= rf_raddr_b;
      out_rd       <= rd;
      out_rs1_data <= rs1_data;
      out_rs2_data <= rs2_data;
      out_opcode   <= opcode;
      out_funct3   <= in_instr[14:12];
      out_funct7_5 <= in_instr[30];
      out_rf_we    <= rf_we;
      out_illegal  <= illegal;
    end else if (!out_valid || out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: table of single-instruction decode vectors
// plus hand-written hazard, hold and flush sequences.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        ex_load_pending;
  logic [4:0]  ex_load_rd;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        out_ready;

  logic        in_ready, out_valid, out_funct7_5, out_rf_we, out_illegal;
  logic [4:0]  rf_raddr_a, rf_raddr_b, out_rs1, out_rs2, out_rd;
  logic [31:0] rf_rdata_a, rf_rdata_b, out_pc, out_imm, out_rs1_data, out_rs2_data;
  logic [3:0]  out_imm_type;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;

  logic        ns_in_ready, ns_out_valid, ns_out_funct7_5, ns_out_rf_we, ns_out_illegal;
  logic [4:0]  ns_raddr_a, ns_raddr_b, ns_out_rs1, ns_out_rs2, ns_out_rd;
  logic [31:0] ns_rdata_a, ns_rdata_b, ns_out_pc, ns_out_imm, ns_out_rs1_data, ns_out_rs2_data;
  logic [3:0]  ns_out_imm_type;
  logic [6:0]  ns_out_opcode;
  logic [2:0]  ns_out_funct3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Register file model: register n holds 0x1000_0000 + n
  assign rf_rdata_a = 32'h1000_0000 | {27'd0, rf_raddr_a};
  assign rf_rdata_b = 32'h1000_0000 | {27'd0, rf_raddr_b};
  assign ns_rdata_a = 32'h1000_0000 | {27'd0, ns_raddr_a};
  assign ns_rdata_b = 32'h1000_0000 | {27'd0, ns_raddr_b};

  decode_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_instr(in_instr), .flush(flush), .ex_load_pending(ex_load_pending), .ex_load_rd(ex_load_rd),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm), .out_imm_type(out_imm_type), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_funct7_5(out_funct7_5), .out_rf_we(out_rf_we), .out_illegal(out_illegal)
  );

  decode_stage #(.EN_SYSTEM(1'b0)) dut_ns (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ns_in_ready), .in_pc(in_pc),
    .in_instr(in_instr), .flush(flush), .ex_load_pending(ex_load_pending), .ex_load_rd(ex_load_rd),
    .rf_raddr_a(ns_raddr_a), .rf_raddr_b(ns_raddr_b), .rf_rdata_a(ns_rdata_a), .rf_rdata_b(ns_rdata_b),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .out_valid(ns_out_valid), .out_ready(out_ready),
    .out_pc(ns_out_pc), .out_imm(ns_out_imm), .out_imm_type(ns_out_imm_type), .out_rs1(ns_out_rs1),
    .out_rs2(ns_out_rs2), .out_rd(ns_out_rd), .out_rs1_data(ns_out_rs1_data), .out_rs2_data(ns_out_rs2_data),
    .out_opcode(ns_out_opcode), .out_funct3(ns_out_funct3), .out_funct7_5(ns_out_funct7_5),
    .out_rf_we(ns_out_rf_we), .out_illegal(ns_out_illegal)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic [31:0] imm;
    logic [3:0]  imm_type;
    logic [4:0]  rd;
    logic        rf_we;
    logic        illegal;
    logic        illegal_ns;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{"addi",   32'hFFF0_0093, 1'b0, 5'd0, 32'h0,         32'hFFFF_FFFF, 4'b1000, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0};
    vecs[1]  = '{"sw_byp", 32'hFE71_2E23, 1'b1, 5'd7, 32'h0000_1234, 32'hFFFF_FFFC, 4'b1010, 5'd0, 1'b0, 1'b0, 1'b0, 32'h1000_0002, 32'h0000_1234};
    vecs[2]  = '{"lui",    32'h1234_52B7, 1'b0, 5'd0, 32'h0,         32'h1234_5000, 4'b1011, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0};
    vecs[3]  = '{"jal",    32'hFF9F_F0EF, 1'b0, 5'd0, 32'h0,         32'hFFFF_FFF8, 4'b1001, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0};
    vecs[4]  = '{"beq",    32'h0020_8863, 1'b1, 5'd0, 32'h0000_DEAD, 32'h0000_0010, 4'b1100, 5'd0, 1'b0, 1'b0, 1'b0, 32'h1000_0001, 32'h1000_0002};
    vecs[5]  = '{"add",    32'h0062_81B3, 1'b1, 5'd5, 32'hCAFE_BABE, 32'h0,         4'b0000, 5'd3, 1'b1, 1'b0, 1'b0, 32'hCAFE_BABE, 32'h1000_0006};
    vecs[6]  = '{"sub_x0", 32'h4000_0033, 1'b0, 5'd0, 32'h0,         32'h0,         4'b0000, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0};
    vecs[7]  = '{"custom", 32'h0000_000B, 1'b0, 5'd0, 32'h0,         32'h0,         4'b0000, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0,         32'h0};
    vecs[8]  = '{"lowbit", 32'hFFF0_0090, 1'b0, 5'd0, 32'h0,         32'h0,         4'b0000, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0,         32'h0};
    vecs[9]  = '{"ecall",  32'h0000_0073, 1'b0, 5'd0, 32'h0,         32'h0,         4'b0000, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h0};
    vecs[10] = '{"auipc",  32'hFFFF_F117, 1'b0, 5'd0, 32'h0,         32'hFFFF_F000, 4'b1011, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0};
    vecs[11] = '{"lw",     32'h0080_A203, 1'b1, 5'd4, 32'h0000_5555, 32'h0000_0008, 4'b1000, 5'd4, 1'b1, 1'b0, 1'b0, 32'h1000_0001, 32'h0};

    reset = 1'b1; in_valid = 1'b0; in_pc = 32'h0; in_instr = 32'h0; flush = 1'b0;
    ex_load_pending = 1'b0; ex_load_rd = 5'd0; wb_we = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'h0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pc", out_pc, 32'h8000_0000);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_imm", out_imm, 32'h0);
    chk("rst_rd", {27'd0, out_rd}, 32'd0);

    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc    = 32'h0000_1000 + 32'(i * 4);
      wb_we    = vecs[i].wb_we;
      wb_waddr = vecs[i].wb_waddr;
      wb_wdata = vecs[i].wb_wdata;
      #1;
      chk({vecs[i].name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      chk({vecs[i].name, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({vecs[i].name, "_pc"}, out_pc, 32'h0000_1000 + 32'(i * 4));
      chk({vecs[i].name, "_imm"}, out_imm, vecs[i].imm);
      chk({vecs[i].name, "_type"}, {28'd0, out_imm_type}, {28'd0, vecs[i].imm_type});
      chk({vecs[i].name, "_rd"}, {27'd0, out_rd}, {27'd0, vecs[i].rd});
      chk({vecs[i].name, "_rf_we"}, {31'd0, out_rf_we}, {31'd0, vecs[i].rf_we});
      chk({vecs[i].name, "_illegal"}, {31'd0, out_illegal}, {31'd0, vecs[i].illegal});
      chk({vecs[i].name, "_illegal_nosys"}, {31'd0, ns_out_illegal}, {31'd0, vecs[i].illegal_ns});
      chk({vecs[i].name, "_rs1_data"}, out_rs1_data, vecs[i].rs1_data);
      chk({vecs[i].name, "_rs2_data"}, out_rs2_data, vecs[i].rs2_data);
      chk({vecs[i].name, "_opcode"}, {25'd0, out_opcode}, {25'd0, vecs[i].instr[6:0]});
    end
    wb_we = 1'b0;

    // Load-use hazard on rs1 of ADD x3,x5,x6, then release
    ex_load_pending = 1'b1; ex_load_rd = 5'd5;
    in_instr = 32'h0062_81B3; in_pc = 32'h0000_3000;
    #1;
    chk("haz_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("haz_bubble", {31'd0, out_valid}, 32'd0);
    ex_load_pending = 1'b0;
    #1;
    chk("haz_release_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("haz_valid", {31'd0, out_valid}, 32'd1);
    chk("haz_pc", out_pc, 32'h0000_3000);
    chk("haz_rd", {27'd0, out_rd}, 32'd3);

    // Pending load to x0 never stalls
    ex_load_pending = 1'b1; ex_load_rd = 5'd0;
    in_instr = 32'hFFF0_0093;
    #1;
    chk("haz_x0_ready", {31'd0, in_ready}, 32'd1);
    ex_load_pending = 1'b0;

    // Hold the ADD bundle with out_ready low, then flush
    out_ready = 1'b0;
    in_instr = 32'h1234_52B7; in_pc = 32'h0000_2000;
    @(negedge clk);
    in_instr = 32'h1234_52B7; in_pc = 32'h0000_2000;
    for (int c = 0; c < 2; c++) begin
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_pc", out_pc, 32'h0000_3000);
      chk("hold_rd", {27'd0, out_rd}, 32'd3);
      chk("hold_rs1_data", out_rs1_data, 32'h1000_0005);
    end
    flush = 1'b1;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    #1;
    chk("post_flush_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("post_flush_valid", {31'd0, out_valid}, 32'd1);
    chk("post_flush_pc", out_pc, 32'h0000_2000);
    chk("post_flush_imm", out_imm, 32'h1234_5000);

    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("empty_bubble", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
